pwm_multichannel_ctrl: RTL and testbench

Multi-channel fan PWM generator: successor to the single-channel PWM controller, with parametrised counter width and channel count. All channels share one period counter, and the block adds edge- or center-aligned counting. Settings are double-buffered and only committed at a period boundary, through a request/acknowledge handshake. Each channel has a per-period duty slew limiter for soft fan start. It sits between the control-loop output registers and the fan driver pins, running on the system clock gated by the shared prescaler enable.

---
 rtl/pwm_pkg.sv | 41 ++++
 rtl/pwm_multichannel_ctrl_slew_channel.sv | 58 +++++
 rtl/pwm_multichannel_ctrl.sv | 141 ++++++++++++++
 tb/tb_pwm_multichannel_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM controller: mode encoding,
// count direction type and helpers for the W+1 bit duty arithmetic.
package pwm_pkg;

    // Counting mode as latched into the shadow register
    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    // Widest datapath the helpers support (W+1 must not exceed this)
    localparam int PWM_MAX_W = 31;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Sum of two W-bit values widened by one bit so it can never wrap
    function automatic logic [PWM_MAX_W:0] pwm_add_ext(
        input logic [PWM_MAX_W-1:0] a,
        input logic [PWM_MAX_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Move cur toward tgt by at most step, landing exactly on tgt when close
    function automatic logic [PWM_MAX_W-1:0] pwm_step_toward(
        input logic [PWM_MAX_W-1:0] cur,
        input logic [PWM_MAX_W-1:0] tgt,
        input logic [PWM_MAX_W-1:0] step
    );
        logic [PWM_MAX_W-1:0] result;
        result = cur;
        if (cur < tgt) begin
            result = ((tgt - cur) > step) ? (cur + step) : tgt;
        end else if (cur > tgt) begin
            result = ((cur - tgt) > step) ? (cur - step) : tgt;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_multichannel_ctrl_slew_channel.sv
// One PWM channel: committed target, slew-limited active duty and the
// registered compare against the shared period counter.
module pwm_slew_channel
    import pwm_pkg::*;
#(
    parameter int W         = 8,
    parameter int SLEW_STEP = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_en_i,
    input  logic       boundary_i,
    input  logic       commit_i,
    input  logic [W:0] cnt_i,
    input  logic [W:0] target_i,
    output logic       pwm_o
);

    logic [W:0] tgt_reg;
    logic [W:0] duty_reg;
    logic [W:0] duty_next;
    logic       pwm_reg;

    // Next active duty: immediate on commit without a slew limit, otherwise
    // one bounded step per boundary toward the target held before this cycle
    always_comb begin
        duty_next = duty_reg;
        if (SLEW_STEP == 0) begin
            if (commit_i) begin
                duty_next = target_i;
            end
        end else if (boundary_i) begin
            duty_next = (W+1)'(pwm_step_toward(PWM_MAX_W'(duty_reg),
                                               PWM_MAX_W'(tgt_reg),
                                               PWM_MAX_W'(SLEW_STEP)));
        end
    end

    // Target/duty registers and the output compare; everything holds while disabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_reg  <= '0;
            duty_reg <= '0;
            pwm_reg  <= 1'b0;
        end else begin
            if (commit_i) begin
                tgt_reg <= target_i;
            end
            duty_reg <= duty_next;
            if (clk_en_i) begin
                pwm_reg <= (cnt_i < duty_reg);
            end
        end
    end

    assign pwm_o = pwm_reg;

endmodule

// File: rtl/pwm_multichannel_ctrl.sv
// Multi-channel fan PWM: shared edge/center-aligned period counter,
// double-buffered settings committed at period boundaries via req/ack,
// and one slew-limited channel per output.
module pwm_multichannel_ctrl
    import pwm_pkg::*;
#(
    parameter int COUNTER_BITWIDTH = 8,
    parameter int CHANNELS         = 2,
    parameter int SLEW_STEP        = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clk_en_i,
    input  logic [COUNTER_BITWIDTH:0]            periodCounterValue_i,
    input  logic [COUNTER_BITWIDTH-1:0]          minCounterValue_i,
    input  logic [CHANNELS*COUNTER_BITWIDTH-1:0] counterValue_i,
    input  logic                                 center_mode_i,
    input  logic                                 update_req_i,
    output logic                                 update_ack_o,
    output logic                                 period_start_o,
    output logic [CHANNELS-1:0]                  PWM_pin_o
);

    localparam int W = COUNTER_BITWIDTH;
    localparam logic [W:0] ONE = (W+1)'(1);

    logic [W:0] cnt_reg;
    logic [W:0] cnt_next;
    pwm_dir_e   dir_reg;
    pwm_dir_e   dir_next;
    logic [W:0] period_reg;
    logic       mode_reg;
    logic       ack_reg;
    logic       period_start_reg;

    logic       boundary;
    logic       commit;
    logic       mode_change;
    logic [W:0] period_eff;

    // Boundary detection for the currently latched mode; P=0 makes every
    // enabled cycle a boundary in both modes
    always_comb begin
        boundary = 1'b0;
        if (clk_en_i) begin
            if (period_reg == '0) begin
                boundary = 1'b1;
            end else if (mode_reg == PWM_MODE_CENTER) begin
                boundary = (dir_reg == DIR_DOWN) && (cnt_reg == '0);
            end else begin
                boundary = (cnt_reg == period_reg);
            end
        end
        commit      = boundary && update_req_i;
        mode_change = commit && (center_mode_i != mode_reg);
        period_eff  = commit ? periodCounterValue_i : period_reg;
    end

    // Counter/direction next state; a boundary already counts against the
    // period being committed so the next cycle belongs to the new period
    always_comb begin
        cnt_next = cnt_reg;
        dir_next = dir_reg;
        if (clk_en_i) begin
            if (mode_change) begin
                cnt_next = '0;
                dir_next = DIR_UP;
            end else if (boundary) begin
                dir_next = DIR_UP;
                if ((mode_reg == PWM_MODE_CENTER) && (period_eff != '0)) begin
                    cnt_next = ONE;
                end else begin
                    cnt_next = '0;
                end
            end else if (mode_reg == PWM_MODE_CENTER) begin
                if (dir_reg == DIR_UP) begin
                    if (cnt_reg >= period_reg) begin
                        cnt_next = cnt_reg - ONE;
                        dir_next = DIR_DOWN;
                    end else begin
                        cnt_next = cnt_reg + ONE;
                    end
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end
    end

    // Shared counter, shadow registers and the one-cycle handshake pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg          <= '0;
            dir_reg          <= DIR_UP;
            period_reg       <= '0;
            mode_reg         <= PWM_MODE_EDGE;
            ack_reg          <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            cnt_reg          <= cnt_next;
            dir_reg          <= dir_next;
            if (commit) begin
                period_reg <= periodCounterValue_i;
                mode_reg   <= center_mode_i;
            end
            ack_reg          <= commit;
            period_start_reg <= boundary;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [W:0] target;

            assign target = (W+1)'(pwm_add_ext(
                                PWM_MAX_W'(counterValue_i[gi*W +: W]),
                                PWM_MAX_W'(minCounterValue_i)));

            pwm_slew_channel #(
                .W         (W),
                .SLEW_STEP (SLEW_STEP)
            ) u_ch (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .clk_en_i   (clk_en_i),
                .boundary_i (boundary),
                .commit_i   (commit),
                .cnt_i      (cnt_reg),
                .target_i   (target),
                .pwm_o      (PWM_pin_o[gi])
            );
        end
    endgenerate

    assign update_ack_o   = ack_reg;
    assign period_start_o = period_start_reg;

endmodule

// File: tb/tb_pwm_multichannel_ctrl.sv
// Self-checking bench: two DUTs (no slew / slew step 4) sharing stimulus,
// a cycle reference model, a table of period scenarios and directed corners.
module tb_pwm_multichannel_ctrl;
    import pwm_pkg::*;

    localparam int W = 8;
    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, en, mode, req;
    logic [W:0]     per;
    logic [W-1:0]   mn;
    logic [N*W-1:0] duty_in;
    logic           ack0, ps0, ack1, ps1;
    logic [N-1:0]   pwm0, pwm1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit toggle_en = 0;

    // reference model state (position-within-period view of the counter)
    int           m_pos, m_P;
    logic         m_mode;
    int           m_tgt[N], m_d0[N], m_d1[N];
    logic [N-1:0] m_pwm0, m_pwm1;
    logic         m_ack, m_ps;

    pwm_multichannel_ctrl #(.COUNTER_BITWIDTH(W), .CHANNELS(N), .SLEW_STEP(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .clk_en_i(en), .periodCounterValue_i(per),
        .minCounterValue_i(mn), .counterValue_i(duty_in), .center_mode_i(mode),
        .update_req_i(req), .update_ack_o(ack0), .period_start_o(ps0), .PWM_pin_o(pwm0));

    pwm_multichannel_ctrl #(.COUNTER_BITWIDTH(W), .CHANNELS(N), .SLEW_STEP(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .clk_en_i(en), .periodCounterValue_i(per),
        .minCounterValue_i(mn), .counterValue_i(duty_in), .center_mode_i(mode),
        .update_req_i(req), .update_ack_o(ack1), .period_start_o(ps1), .PWM_pin_o(pwm1));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int slew(input int cur, input int tgt, input int step);
        int d;
        d = tgt - cur;
        if (d > step)  d = step;
        if (d < -step) d = -step;
        return cur + d;
    endfunction

    // advance the model by one clock using the inputs the DUT is about to sample
    task automatic model_step();
        int cnt, new_p;
        bit bnd, com;
        if (rst) begin
            m_pos = 0; m_P = 0; m_mode = PWM_MODE_EDGE;
            m_pwm0 = '0; m_pwm1 = '0; m_ack = 0; m_ps = 0;
            for (int k = 0; k < N; k++) begin
                m_tgt[k] = 0; m_d0[k] = 0; m_d1[k] = 0;
            end
            return;
        end
        if (!en) begin
            m_ack = 0; m_ps = 0;
            return;
        end
        cnt = (m_mode == PWM_MODE_CENTER && m_pos > m_P) ? 2 * m_P - m_pos : m_pos;
        bnd = (m_P == 0) || (m_pos == ((m_mode == PWM_MODE_CENTER) ? 2 * m_P : m_P));
        com = bnd && req;
        for (int k = 0; k < N; k++) begin
            m_pwm0[k] = (cnt < m_d0[k]);
            m_pwm1[k] = (cnt < m_d1[k]);
        end
        m_ack = com;
        m_ps  = bnd;
        if (bnd)
            for (int k = 0; k < N; k++) m_d1[k] = slew(m_d1[k], m_tgt[k], 4);
        new_p = com ? int'(per) : m_P;
        if (com && mode != m_mode)  m_pos = 0;
        else if (bnd)               m_pos = (m_mode == PWM_MODE_CENTER && new_p > 0) ? 1 : 0;
        else                        m_pos = m_pos + 1;
        if (com) begin
            m_P = new_p;
            m_mode = mode;
            for (int k = 0; k < N; k++) begin
                m_tgt[k] = int'(duty_in[k*W +: W]) + int'(mn);
                m_d0[k]  = m_tgt[k];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("dut0_outputs", int'({pwm0, ack0, ps0}), int'({m_pwm0, m_ack, m_ps}));
        check("dut1_outputs", int'({pwm1, ack1, ps1}), int'({m_pwm1, m_ack, m_ps}));
        if (toggle_en) en = ~en;
    endtask

    task automatic request(input int p, input int m, input int a, input int b, input logic md);
        int n;
        per = 9'(p); mn = 8'(m); duty_in = {8'(b), 8'(a)}; mode = md; req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ack0 && n < 300);
        check("ack_seen", int'(ack0), 1);
        req = 1'b0;
    endtask

    task automatic wait_ps();
        int n;
        n = 0;
        do begin tick(); n++; end while (!ps0 && n < 600);
        check("period_start_seen", int'(ps0), 1);
    endtask

    // count cycles and high cycles from the current period_start to the next
    task automatic measure(output int len, output int h0, output int h1, output int h2);
        len = 0; h0 = 0; h1 = 0; h2 = 0;
        do begin
            h0 += int'(pwm0[0]); h1 += int'(pwm0[1]); h2 += int'(pwm1[0]);
            len++;
            tick();
        end while (!ps0 && len < 600);
    endtask

    typedef struct {
        int p; int m; int d0; int d1; logic md;
        int exp_len; int exp_h0; int exp_h1;
    } vec_t;

    vec_t vecs[7];
    int   slew_exp[5];

    initial begin
        int len, h0, h1, h2, n;

        vecs[0] = '{9, 0, 3,  0, PWM_MODE_EDGE,   10, 3,  0};
        vecs[1] = '{9, 0, 15, 9, PWM_MODE_EDGE,   10, 10, 9};
        vecs[2] = '{8, 0, 2,  0, PWM_MODE_CENTER, 16, 3,  0};
        vecs[3] = '{8, 1, 2,  8, PWM_MODE_CENTER, 16, 5,  16};
        vecs[4] = '{5, 2, 1,  4, PWM_MODE_EDGE,   6,  3,  6};
        vecs[5] = '{0, 0, 0,  1, PWM_MODE_EDGE,   1,  0,  1};
        vecs[6] = '{0, 0, 1,  0, PWM_MODE_CENTER, 1,  1,  0};
        slew_exp = '{0, 4, 8, 10, 10};

        rst = 1; en = 1; mode = 0; req = 0; per = '0; mn = '0; duty_in = '0;
        tick();
        tick();
        check("reset_state", int'({pwm0, ack0, ps0, pwm1, ack1, ps1}), 0);
        rst = 0;

        // table of period scenarios
        for (int i = 0; i < 7; i++) begin
            request(vecs[i].p, vecs[i].m, vecs[i].d0, vecs[i].d1, vecs[i].md);
            wait_ps();
            measure(len, h0, h1, h2);
            check($sformatf("vec%0d_period", i), len, vecs[i].exp_len);
            check($sformatf("vec%0d_high_ch0", i), h0, vecs[i].exp_h0);
            check($sformatf("vec%0d_high_ch1", i), h1, vecs[i].exp_h1);
        end

        // slew limiter: 0 -> 10 with step 4
        request(15, 0, 0, 0, PWM_MODE_EDGE);
        wait_ps();
        request(15, 0, 10, 0, PWM_MODE_EDGE);
        for (int i = 0; i < 5; i++) begin
            measure(len, h0, h1, h2);
            check($sformatf("slew_period%0d_high", i), h2, slew_exp[i]);
            if (i == 0) check("no_slew_immediate_high", h0, 10);
        end

        // mid-period request, P 20 -> 5
        request(20, 0, 5, 0, PWM_MODE_EDGE);
        wait_ps();
        for (int i = 0; i < 7; i++) tick();
        per = 9'd5; req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ack0 && n < 100);
        check("midreq_cycles_to_ack", n, 14);
        check("midreq_ack_with_period_start", int'(ps0), 1);
        req = 1'b0;
        measure(len, h0, h1, h2);
        check("midreq_new_period", len, 6);

        // enable toggling, reset mid-period, request held through reset
        toggle_en = 1;
        request(30, 0, 4, 0, PWM_MODE_EDGE);
        for (int i = 0; i < 9; i++) tick();
        rst = 1; per = 9'd3; duty_in = {8'd0, 8'd1}; req = 1'b1;
        tick();
        check("reset_outputs_low", int'({pwm0, ack0, ps0, pwm1, ack1, ps1}), 0);
        toggle_en = 0;
        rst = 0; en = 0;
        tick();
        check("ack_while_disabled", int'(ack0), 0);
        en = 1;
        tick();
        check("ack_first_enabled", int'(ack0), 1);
        req = 0; en = 0; toggle_en = 1;
        wait_ps();
        measure(len, h0, h1, h2);
        check("toggled_period_cycles", len, 8);
        check("toggled_high_cycles", h0, 2);
        toggle_en = 0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if (req && m_ack) begin
                req = 1'b0;
            end else if (!req && $urandom_range(0, 11) == 0) begin
                per = 9'($urandom_range(0, 20));
                mn = 8'($urandom_range(0, 5));
                duty_in = {8'($urandom_range(0, 25)), 8'($urandom_range(0, 25))};
                mode = 1'($urandom_range(0, 1));
                req = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
